// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: geometry, entry index and entry record.
// Imported by the ROB, the ALU and the dispatch logic so the index type agrees everywhere.
package rob_pkg;

    localparam int ROB_DEPTH = 4;
    localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
    localparam int DATA_W    = 3;
    localparam int DEST_W    = 3;

    typedef logic [ROB_IDX_W-1:0] rob_idx_t;
    typedef logic [ROB_IDX_W:0]   rob_cnt_t;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_buffer.sv
// 4-entry reorder buffer: in-order allocate, out-of-order writeback, in-order commit from the head.
// Latency: a writeback makes commit_valid visible the next cycle; a commit frees its slot the next cycle.
// Backpressure: alloc_ready drops when full (no same-cycle bypass); the head holds while commit_ready is low.
module rob_buffer
    import rob_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 alloc_valid,
    input  logic [DEST_W-1:0]    alloc_dest,
    output logic                 alloc_ready,
    output logic [ROB_IDX_W-1:0] alloc_idx,
    input  logic                 wb_valid,
    input  logic [ROB_IDX_W-1:0] wb_idx,
    input  logic [DATA_W-1:0]    wb_data,
    output logic                 commit_valid,
    input  logic                 commit_ready,
    output logic [ROB_IDX_W-1:0] commit_idx,
    output logic [DEST_W-1:0]    commit_dest,
    output logic [DATA_W-1:0]    commit_data,
    output logic [ROB_IDX_W:0]   count
);

    rob_entry_t entries [ROB_DEPTH];
    rob_idx_t   head;
    rob_idx_t   tail;
    rob_cnt_t   cnt_q;

    logic alloc_fire;
    logic wb_fire;
    logic commit_fire;

    // All outputs come straight from registered state.
    assign alloc_ready  = (cnt_q < rob_cnt_t'(ROB_DEPTH));
    assign alloc_idx    = tail;
    assign commit_valid = entries[head].valid && entries[head].done;
    assign commit_idx   = head;
    assign commit_dest  = entries[head].dest;
    assign commit_data  = entries[head].data;
    assign count        = cnt_q;

    assign alloc_fire  = alloc_valid && alloc_ready;
    assign commit_fire = commit_valid && commit_ready;
    // An entry allocated this cycle is still invalid here, so a writeback to it is dropped.
    assign wb_fire     = wb_valid && entries[wb_idx].valid && !entries[wb_idx].done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].done  <= 1'b0;
            end
        end else begin
            // Writeback, allocate and commit never touch the same entry in one cycle.
            if (wb_fire) begin
                entries[wb_idx].done <= 1'b1;
                entries[wb_idx].data <= wb_data;
            end
            if (alloc_fire) begin
                entries[tail].valid <= 1'b1;
                entries[tail].done  <= 1'b0;
                entries[tail].dest  <= alloc_dest;
                tail                <= tail + rob_idx_t'(1);
            end
            if (commit_fire) begin
                entries[head].valid <= 1'b0;
                entries[head].done  <= 1'b0;
                head                <= head + rob_idx_t'(1);
            end
            case ({alloc_fire, commit_fire})
                2'b10:   cnt_q <= cnt_q + rob_cnt_t'(1);
                2'b01:   cnt_q <= cnt_q - rob_cnt_t'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_rob_buffer.sv
// Bench for rob_buffer: program-order queue model checked every cycle, plus directed literal checks.
module tb_rob_buffer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       alloc_valid = 1'b0;
    logic [2:0] alloc_dest = '0;
    logic       alloc_ready;
    logic [1:0] alloc_idx;
    logic       wb_valid = 1'b0;
    logic [1:0] wb_idx = '0;
    logic [2:0] wb_data = '0;
    logic       commit_valid;
    logic       commit_ready = 1'b0;
    logic [1:0] commit_idx;
    logic [2:0] commit_dest;
    logic [2:0] commit_data;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    rob_buffer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_idx(commit_idx), .commit_dest(commit_dest),
        .commit_data(commit_data), .count(count)
    );

    always #5 clk = ~clk;

    // Model: in-flight instructions in program order; the ROB index is implied by position.
    typedef struct {
        int idx;
        int dest;
        bit done;
        int data;
    } m_ent_t;

    m_ent_t q[$];
    int     m_head = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            q.delete();
            m_head = 0;
        end else begin
            int  sz;
            int  t;
            bit  a_fire;
            bit  c_fire;
            sz     = q.size();
            t      = (m_head + sz) % 4;
            a_fire = alloc_valid && (sz < 4);
            c_fire = commit_ready && (sz > 0) && q[0].done;
            if (wb_valid) begin
                foreach (q[i]) begin
                    if (q[i].idx == int'(wb_idx) && !q[i].done) begin
                        q[i].done = 1'b1;
                        q[i].data = int'(wb_data);
                    end
                end
            end
            if (c_fire) begin
                void'(q.pop_front());
                m_head = (m_head + 1) % 4;
            end
            if (a_fire) begin
                m_ent_t e;
                e.idx  = t;
                e.dest = int'(alloc_dest);
                e.done = 1'b0;
                e.data = 0;
                q.push_back(e);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit cv;
        cv = (q.size() > 0) && q[0].done;
        chk("m_count", int'(count), q.size());
        chk("m_alloc_ready", int'(alloc_ready), int'(q.size() < 4));
        chk("m_alloc_idx", int'(alloc_idx), (m_head + q.size()) % 4);
        chk("m_commit_valid", int'(commit_valid), int'(cv));
        chk("m_commit_idx", int'(commit_idx), m_head);
        if (cv) begin
            chk("m_commit_dest", int'(commit_dest), q[0].dest);
            chk("m_commit_data", int'(commit_data), q[0].data);
        end
    end

    // Drive one cycle of inputs (called just after a falling edge), then land after the next falling edge.
    task automatic step(input bit av, input int ad, input bit wv, input int wi,
                        input int wd, input bit cr, input bit fl);
        alloc_valid  = av;
        alloc_dest   = 3'(ad);
        wb_valid     = wv;
        wb_idx       = 2'(wi);
        wb_data      = 3'(wd);
        commit_ready = cr;
        flush        = fl;
        @(negedge clk);
        #1;
        alloc_valid  = 1'b0;
        wb_valid     = 1'b0;
        commit_ready = 1'b0;
        flush        = 1'b0;
    endtask

    initial begin
        #1;
        chk("reset_alloc_ready", int'(alloc_ready), 1);
        chk("reset_alloc_idx", int'(alloc_idx), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_commit_valid", int'(commit_valid), 0);
        chk("reset_commit_dest", int'(commit_dest), 0);
        chk("reset_commit_data", int'(commit_data), 0);
        @(negedge clk); @(negedge clk);
        #1 rst_n = 1'b1;

        // Single instruction round trip.
        chk("t1_alloc_idx", int'(alloc_idx), 0);
        step(1, 5, 0, 0, 0, 0, 0);
        chk("t1_count", int'(count), 1);
        chk("t1_cv_before_wb", int'(commit_valid), 0);
        step(0, 0, 1, 0, 3, 0, 0);
        chk("t1_commit_valid", int'(commit_valid), 1);
        chk("t1_commit_dest", int'(commit_dest), 5);
        chk("t1_commit_data", int'(commit_data), 3);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("t1_count_after", int'(count), 0);

        // Fill to full, refuse a fifth.
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t2_alloc_idx", int'(alloc_idx), i);
            step(1, i + 1, 0, 0, 0, 0, 0);
        end
        chk("t2_count_full", int'(count), 4);
        chk("t2_alloc_ready_full", int'(alloc_ready), 0);
        step(1, 7, 0, 0, 0, 0, 0);
        chk("t2_count_refused", int'(count), 4);

        // Full + commit + alloc: commit fires, alloc refused, slot visible next cycle.
        step(0, 0, 1, 0, 7, 0, 0);
        chk("t4_head_dest", int'(commit_dest), 1);
        step(1, 6, 0, 0, 0, 1, 0);
        chk("t4_count", int'(count), 3);
        chk("t4_alloc_ready", int'(alloc_ready), 1);
        chk("t4_alloc_idx_wrap", int'(alloc_idx), 0);
        step(1, 6, 0, 0, 0, 0, 0);
        chk("t4_count_refill", int'(count), 4);

        // Out-of-order writeback, in-order commit.
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, i + 2, 0, 0, 0, 0, 0);
        step(0, 0, 1, 2, 1, 0, 0);
        chk("t3_cv_after_wb2", int'(commit_valid), 0);
        step(0, 0, 1, 1, 2, 0, 0);
        chk("t3_cv_after_wb1", int'(commit_valid), 0);
        step(0, 0, 1, 0, 4, 0, 0);
        for (int i = 0; i < 3; i++) begin
            int exp_data [3] = '{4, 2, 1};
            chk("t3_commit_valid", int'(commit_valid), 1);
            chk("t3_commit_idx", int'(commit_idx), i);
            chk("t3_commit_data", int'(commit_data), exp_data[i]);
            step(0, 0, 0, 0, 0, 1, 0);
        end
        chk("t3_count", int'(count), 0);

        // Stray and duplicate writebacks (head and tail are now 3).
        step(0, 0, 1, 3, 5, 0, 0);
        chk("t5_stray_cv", int'(commit_valid), 0);
        chk("t5_stray_count", int'(count), 0);
        step(1, 2, 0, 0, 0, 0, 0);
        step(0, 0, 1, 3, 1, 0, 0);
        chk("t5_first_data", int'(commit_data), 1);
        step(0, 0, 1, 3, 6, 0, 0);
        chk("t5_dup_data", int'(commit_data), 1);
        step(0, 0, 0, 0, 0, 1, 0);

        // Flush beats everything else in the same cycle.
        for (int i = 0; i < 3; i++) step(1, i, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 2, 0, 0);
        chk("t6_count_pre", int'(count), 3);
        step(1, 4, 1, 1, 3, 1, 1);
        chk("t6_flush_count", int'(count), 0);
        chk("t6_flush_alloc_idx", int'(alloc_idx), 0);
        chk("t6_flush_cv", int'(commit_valid), 0);

        // Asynchronous reset mid-stream.
        step(1, 3, 0, 0, 0, 0, 0);
        step(1, 4, 1, 0, 5, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_arst_count", int'(count), 0);
        chk("t6_arst_alloc_idx", int'(alloc_idx), 0);
        chk("t6_arst_cv", int'(commit_valid), 0);
        chk("t6_arst_commit_data", int'(commit_data), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                #1 rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_buffer.md
Name: rob_buffer

Overview:
- 4-entry reorder buffer that sits directly downstream of the ALU.
- Dispatch allocates an entry in program order and receives a 2-bit ROB index, which travels with the instruction to the ALU.
- The ALU's done/result/result_rob_idx write back into that entry.
- Completed entries retire strictly in order from the head through a valid/ready commit port.

Parameters:
- DEPTH, 4, number of entries; power of two; index width is clog2(DEPTH) = 2.
- DATA_W, 3, result width; matches ALU result.
- DEST_W, 3, architectural destination register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- flush  in  1  synchronous clear of all entries
- alloc_valid  in  1  dispatch requests an entry
- alloc_dest  in  DEST_W  destination register of the dispatched instruction
- alloc_ready  out  1  an entry is free (count < DEPTH)
- alloc_idx  out  2  index granted (current tail); meaningful when alloc_ready
- wb_valid  in  1  writeback strobe; wired to ALU done
- wb_idx  in  2  entry being completed; wired to ALU result_rob_idx
- wb_data  in  DATA_W  result value; wired to ALU result
- commit_valid  out  1  head entry is valid and done
- commit_ready  in  1  retire stage accepts the head
- commit_idx  out  2  head index
- commit_dest  out  DEST_W  head destination register
- commit_data  out  DATA_W  head result
- count  out  3  occupied entries, 0..DEPTH

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low.
- Reset values: head=0, tail=0, count=0, all entry valid/done=0.
  - Outputs at reset: alloc_ready=1, alloc_idx=0, commit_valid=0, commit_idx=0; commit_dest and commit_data read as 0.
- Per-entry state: valid, done, dest, data. head and tail are 2-bit pointers that wrap naturally (3 -> 0). count disambiguates full from empty.
- Allocate fires on alloc_valid && alloc_ready:
  - entry[tail] gets valid=1, done=0, dest=alloc_dest.
  - tail+1; count+1.
  - alloc_idx/alloc_ready are combinational from registered state; the granted index is the pre-increment tail.
- Writeback: when wb_valid && entry[wb_idx].valid && !entry[wb_idx].done, set done=1 and data=wb_data.
  - Writeback to an invalid or already-done entry is ignored with no state change.
  - Latency: commit_valid can rise the cycle after the writeback.
  - The ALU done pulse is single-cycle; every cycle wb_valid is high is sampled.
- Commit:
  - commit_valid = entry[head].valid && entry[head].done, combinational from registers.
  - Fires on commit_valid && commit_ready: entry[head].valid/done cleared, head+1, count-1.
  - commit_* hold stable while commit_valid=1 and commit_ready=0.
- Simultaneous events in one cycle:
  - Alloc + commit: count unchanged; both pointers advance.
  - Full (count=4): alloc_ready=0 even if a commit fires the same cycle; no bypass. The freed slot is visible next cycle.
  - Writeback to the entry being allocated this cycle: the entry is not yet valid, so the writeback is ignored.
  - Writeback + commit on different entries: both take effect.
  - A writeback cannot target the committing head, because that entry is already done.
- Flush has priority over alloc, writeback and commit in the same cycle.
  - Clears all valid/done bits and sets head=tail=count=0.
  - Next cycle: alloc_ready=1, commit_valid=0.
- Asynchronous reset mid-operation discards all entries immediately; the state is identical to the post-reset state.
- No out-of-order commit; only the head can retire.

Decomposition:
- Shared package rob_pkg holds:
  - ROB_DEPTH=4, ROB_IDX_W=2, DATA_W=3, DEST_W=3
  - typedef rob_idx_t
  - typedef struct rob_entry_t {valid, done, dest, data}
- The ALU and dispatch logic import rob_idx_t from the same package.
- Single module; no sub-module. Pointer/count logic is too small to split out.

Test Plan:
- Reset, then alloc dest=5 -> alloc_idx=0, count=1. wb idx=0 data=3 -> next cycle commit_valid=1, commit_dest=5, commit_data=3. commit_ready=1 -> count=0.
- Alloc 4 entries (dest 1..4) -> alloc_idx 0,1,2,3 and count=4, alloc_ready=0. A 5th alloc_valid is refused with no state change.
- Out-of-order writeback: entries 0..2 allocated; wb idx=2 then idx=1 -> commit_valid stays 0. wb idx=0 -> commits retire in order 0,1,2 with the correct data.
- Full buffer with head done and commit_ready=1 plus alloc_valid in the same cycle -> commit fires, alloc refused. Next cycle alloc_ready=1 and alloc_idx=0 (wrap); a following alloc gives count=4.
- Stray writeback: wb idx=3 with entry 3 invalid -> no change. Duplicate wb to a done entry with data=6 -> original data retained.
- Flush with alloc_valid, wb_valid and commit_ready all high, count=3 -> next cycle count=0, alloc_idx=0, commit_valid=0. Async reset asserted mid-stream gives the same result.
